sram_1rw_req_ctrl: RTL
======================

Name: sram_1rw_req_ctrl

Overview:
- Initiator-side controller for the single-port 1rw SRAM macro interface: valid/write/addr/wdata out, rdata in, one-cycle read latency.
- Converts a ready/valid request stream, with byte-masked writes, into legal SRAM cycles.
- Performs read-modify-write for partial-mask writes.
- Returns read data on a ready/valid response stream through a credit-managed response FIFO.
- Sits between the vector load/store unit and each 256x256 SRAM bank.

Parameters:
- AW, 8, SRAM address width.
- DW, 256, data width in bits.
- MW, DW/8, byte-mask width.
- RSP_DEPTH, 2, response FIFO entries; minimum 2.

Ports:
- clock  in  1  single clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- req_wmask  in  MW  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DW  read data.
- volt_sel  in  1  voltage select, passed through.
- sram_valid  out  1  SRAM access strobe.
- sram_write  out  1  SRAM write enable.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  DW  SRAM write data.
- sram_rdata  in  DW  SRAM read data; valid only in the cycle after a read access.
- sram_volt_sel  out  1  equals volt_sel.

Behaviour:
- States:
  - IDLE: accepts requests.
  - RMW: read phase of a partial write done; write phase issued this cycle.
- Reset (async) state:
  - state = IDLE, FIFO empty, rd_pending = 0, RMW latches cleared.
  - While reset is high: req_ready = 0, rsp_valid = 0, sram_valid = 0.
- req_ready = (state == IDLE) && (fifo_count + rd_pending < RSP_DEPTH) && !reset.
  - req_ready must not depend on req_write, req_addr or req_wmask.
- IDLE, accepted read:
  - Same cycle: sram_valid = 1, sram_write = 0, sram_addr = req_addr (combinational).
  - rd_pending = 1 next cycle.
- rd_pending cycle: sram_rdata is pushed into the FIFO at the end of that cycle, unconditionally. Credit accounting guarantees space.
- Read latency: accepted in cycle N → rsp_valid earliest in cycle N+2. No bypass.
- IDLE, accepted write, wmask all ones:
  - Same cycle: sram_valid = 1, sram_write = 1, sram_addr/sram_wdata = request.
  - No response is generated.
- IDLE, accepted write, wmask == 0: no SRAM access, no response, request consumed.
- IDLE, accepted write, partial mask:
  - Same cycle: SRAM read of req_addr.
  - Latch addr, wdata and wmask; next state RMW.
- RMW cycle:
  - sram_valid = 1, sram_write = 1, sram_addr = latched addr.
  - sram_wdata byte i = mask[i] ? latched wdata byte i : sram_rdata byte i.
  - Next state IDLE; req_ready = 0 for exactly this one cycle.
  - The RMW read never enters the FIFO and never sets rd_pending.
- Ordering:
  - At most one SRAM access per cycle.
  - Requests execute strictly in acceptance order.
  - A read following a write to the same address returns the new data.
- Response FIFO:
  - Order preserved.
  - Pop on rsp_valid && rsp_ready.
  - rsp_rdata is stable while rsp_valid && !rsp_ready.
  - Push and pop in the same cycle is allowed; the count is unchanged.
- Credit rule: fifo_count + rd_pending never exceeds RSP_DEPTH; an assertion checks this.
- Reset during RMW:
  - sram_valid drops immediately and the merged write is not performed.
  - An in-flight read is discarded; FIFO contents are discarded.
- sram_volt_sel = volt_sel, combinational.

Test Plan:
- Full-mask write of addr 0x05 with data 0xA5 repeated, then read of 0x05 with rsp_ready=1 → exactly one SRAM write and one SRAM read; rsp_valid 2 cycles after read acceptance; rsp_rdata = 0xA5 repeated.
- Preload addr 0x10 = all 0xFF; write wmask=0x00000001, wdata byte0=0xAA → SRAM read then write on consecutive cycles; req_ready low for 1 cycle; readback = 0xFF..FFAA.
- Backpressure: rsp_ready=0, three back-to-back reads of 0x01/0x02/0x03 → only two accepted, req_ready stays 0; raise rsp_ready → responses 0x01 then 0x02 data; third read then accepted and returns 0x03 data.
- Write with wmask=0 to 0x20 → request consumed in one cycle; sram_valid never asserts; later read of 0x20 returns the prior contents.
- Partial write to 0x30 immediately followed by a read of 0x30 (back-to-back valid) → read accepted 2 cycles after the write; returns merged data; no overlap of SRAM accesses.
- Assert reset in the RMW cycle → sram_valid = 0 that cycle; 0x30 keeps its old value; after reset, req_ready = 1 and rsp_valid = 0.

Source files
------------

// File: rtl/sram_1rw_req_ctrl_if.sv
// Request, response and SRAM-macro signals of one 1rw bank controller.
// The slave modport is the controller's view; master is the LSU plus SRAM side.
interface sram_1rw_req_ctrl_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 256,
   parameter int unsigned MW = DW / 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [MW-1:0] req_wmask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          sram_valid;
   logic          sram_write;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready, sram_rdata,
      output req_ready, rsp_valid, rsp_rdata, sram_valid, sram_write, sram_addr, sram_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready, sram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, sram_valid, sram_write, sram_addr, sram_wdata
   );
endinterface

// File: rtl/sram_1rw_req_ctrl.sv
// Initiator-side controller for a 1rw SRAM bank: byte-masked writes with read-modify-write,
// reads returned through a credit-managed response FIFO.
module sram_1rw_req_ctrl #(
   parameter int unsigned AW        = 8,
   parameter int unsigned DW        = 256,
   parameter int unsigned MW        = DW / 8,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_volt_sel,
   output logic                 o_sram_volt_sel,
   sram_1rw_req_ctrl_if.slave   bus
);
   localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   typedef enum logic [0:0] {StIdle, StRmw} state_e;

   state_e        r_state;
   logic          r_rd_pending;
   logic [AW-1:0] r_rmw_addr;
   logic [DW-1:0] r_rmw_wdata;
   logic [MW-1:0] r_rmw_wmask;
   logic [DW-1:0] r_fifo [RSP_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [CW:0]   w_used;
   logic          w_req_ready;
   logic          w_accept;
   logic          w_full_mask;
   logic          w_zero_mask;
   logic          w_partial;
   logic          w_push;
   logic          w_pop;
   logic [DW-1:0] w_merged;

   // Credits cover both queued responses and the read whose data arrives next cycle.
   assign w_used      = {1'b0, r_count} + {{CW{1'b0}}, r_rd_pending};
   assign w_req_ready = (r_state == StIdle) && (w_used < (CW+1)'(RSP_DEPTH)) && !i_reset;
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_full_mask = &bus.req_wmask;
   assign w_zero_mask = ~|bus.req_wmask;
   assign w_partial   = bus.req_write && !w_full_mask && !w_zero_mask;
   assign w_push      = r_rd_pending;
   assign w_pop       = (r_count != '0) && bus.rsp_ready;

   assign bus.req_ready   = w_req_ready;
   assign bus.rsp_valid   = (r_count != '0) && !i_reset;
   assign bus.rsp_rdata   = r_fifo[r_rd_ptr];
   assign o_sram_volt_sel = i_volt_sel;

   always_comb begin
      w_merged = '0;
      for (int i = 0; i < int'(MW); i++) begin
         w_merged[8*i +: 8] = r_rmw_wmask[i] ? r_rmw_wdata[8*i +: 8] : bus.sram_rdata[8*i +: 8];
      end
   end

   always_comb begin
      bus.sram_valid = 1'b0;
      bus.sram_write = 1'b0;
      bus.sram_addr  = bus.req_addr;
      bus.sram_wdata = bus.req_wdata;
      if (r_state == StRmw) begin
         bus.sram_valid = !i_reset;
         bus.sram_write = 1'b1;
         bus.sram_addr  = r_rmw_addr;
         bus.sram_wdata = w_merged;
      end else if (w_accept) begin
         // Partial writes issue their read phase here; empty-mask writes touch nothing.
         bus.sram_valid = !bus.req_write || !w_zero_mask;
         bus.sram_write = bus.req_write && w_full_mask;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_rd_pending <= 1'b0;
         r_rmw_addr   <= '0;
         r_rmw_wdata  <= '0;
         r_rmw_wmask  <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         r_rd_pending <= w_accept && !bus.req_write;
         unique case (r_state)
            StIdle: begin
               if (w_accept && w_partial) begin
                  r_rmw_addr  <= bus.req_addr;
                  r_rmw_wdata <= bus.req_wdata;
                  r_rmw_wmask <= bus.req_wmask;
                  r_state     <= StRmw;
               end
            end
            StRmw:   r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= bus.sram_rdata;
      end
   end

   a_credit: assert property (@(posedge i_clock) disable iff (i_reset)
      w_used <= (CW+1)'(RSP_DEPTH));
endmodule
